// File: rtl/button_pkg.sv
// button_pkg
//   Shared definitions for the push-button front end: per-channel FSM state
//   encoding and the default count constants used by button_conditioner and
//   debounce_sync.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    localparam int NUM_CH = 2;

    localparam int DEF_CNT_W        = 16;
    localparam int DEF_DEBOUNCE_CNT = 8;
    localparam int DEF_HOLD_CNT     = 32;
    localparam int DEF_REPEAT_CNT   = 8;

endpackage

// File: rtl/debounce_sync.sv
// debounce_sync
//   One-bit synchroniser plus debouncer. The raw input passes through two
//   flops; only the second is used. The debounced level (stable_o) flips once
//   the synchronised input has disagreed with it for DEBOUNCE_CNT consecutive
//   cycles; any shorter disagreement is forgotten.
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   raw_i     in   raw, asynchronous, bouncy button level
//   stable_o  out  debounced level
module debounce_sync
    import button_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CNT - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter holds the number of disagreeing cycles already seen; the
    // DEBOUNCE_CNT-th one flips the level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == DEB_LAST) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   Front end of the PWM generator. Conditions the raw increment and decrement
//   buttons into clean one-cycle step pulses (sum / rest, feeding the
//   contadorSelector sum/rest inputs) with hold-to-repeat, plus the debounced
//   button levels.
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   btn_sum_in   in   raw increment button
//   btn_rest_in  in   raw decrement button
//   sum          out  one-cycle increment pulse
//   rest         out  one-cycle decrement pulse
//   sum_held     out  debounced increment level (registered)
//   rest_held    out  debounced decrement level (registered)
//
// Per-channel FSM
//   state  | meaning
//   IDLE   | button released; waiting for the debounced press
//   HOLD   | first pulse issued; counting HOLD_CNT cycles to auto-repeat
//   REPEAT | auto-repeating, one pulse every REPEAT_CNT cycles
module button_conditioner
    import button_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
    parameter int HOLD_CNT     = DEF_HOLD_CNT,
    parameter int REPEAT_CNT   = DEF_REPEAT_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_sum_in,
    input  logic btn_rest_in,
    output logic sum,
    output logic rest,
    output logic sum_held,
    output logic rest_held
);

    if (DEBOUNCE_CNT < 1 || HOLD_CNT < 1 || REPEAT_CNT < 1 ||
        (DEBOUNCE_CNT >> CNT_W) != 0 || (HOLD_CNT >> CNT_W) != 0 ||
        (REPEAT_CNT >> CNT_W) != 0) begin : g_bad_params
        $error("button_conditioner: counts must be >= 1 and < 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] pulse;

    debounce_sync #(
        .CNT_W        (CNT_W),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_db_sum (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (btn_sum_in),
        .stable_o (stable[0])
    );

    debounce_sync #(
        .CNT_W        (CNT_W),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_db_rest (
        .clk      (clk),
        .rst      (rst),
        .raw_i    (btn_rest_in),
        .stable_o (stable[1])
    );

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        btn_state_e       state_q, state_d;
        logic [CNT_W-1:0] timer_q, timer_d;
        logic             pulse_q, pulse_d;

        // Leaving HOLD/REPEAT always requires stable==0, so a 1 seen in IDLE
        // is necessarily a fresh press. Release wins over a coincident
        // terminal count, so no pulse is issued on the way out.
        always_comb begin
            state_d = state_q;
            timer_d = timer_q;
            pulse_d = 1'b0;
            case (state_q)
                IDLE: begin
                    timer_d = '0;
                    if (stable[g]) begin
                        state_d = HOLD;
                        pulse_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stable[g]) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (timer_q == HOLD_LAST) begin
                        state_d = REPEAT;
                        timer_d = '0;
                        pulse_d = 1'b1;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (!stable[g]) begin
                        state_d = IDLE;
                        timer_d = '0;
                    end else if (timer_q == REPEAT_LAST) begin
                        timer_d = '0;
                        pulse_d = 1'b1;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                timer_q <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                pulse_q <= pulse_d;
            end
        end

        assign pulse[g] = pulse_q;
    end

    // Both FSMs keep their schedules while both buttons are down; only the
    // outputs are suppressed, so a surviving button carries on its own grid.
    logic both_down;
    logic sum_q, sum_d;
    logic rest_q, rest_d;
    logic sum_held_q, rest_held_q;

    assign both_down = stable[0] & stable[1];
    assign sum_d     = pulse[0] & ~both_down;
    assign rest_d    = pulse[1] & ~both_down;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= 1'b0;
            rest_q      <= 1'b0;
            sum_held_q  <= 1'b0;
            rest_held_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            rest_q      <= rest_d;
            sum_held_q  <= stable[0];
            rest_held_q <= stable[1];
        end
    end

    assign sum       = sum_q;
    assign rest      = rest_q;
    assign sum_held  = sum_held_q;
    assign rest_held = rest_held_q;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int DEB  = 8;
    localparam int HOLD = 32;
    localparam int REP  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_sum_in = 1'b0;
    logic btn_rest_in = 1'b0;
    logic sum, rest, sum_held, rest_held;

    button_conditioner #(
        .CNT_W        (16),
        .DEBOUNCE_CNT (DEB),
        .HOLD_CNT     (HOLD),
        .REPEAT_CNT   (REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_sum_in  (btn_sum_in),
        .btn_rest_in (btn_rest_in),
        .sum         (sum),
        .rest        (rest),
        .sum_held    (sum_held),
        .rest_held   (rest_held)
    );

    always #5 clk = ~clk;

    // cyc == n during the cycle that follows rising edge n
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per channel: a 2-sample delay of the raw level, a run length of
    // consecutive synced samples that disagree with the accepted level, and
    // the number of cycles the accepted level has been 1. Pulses fall on
    // fixed offsets of that length; the output is the pulse one cycle later,
    // suppressed when both accepted levels were 1.
    function automatic bit fires(input int len);
        return (len == 1) || (len >= HOLD + 1 && ((len - 1 - HOLD) % REP) == 0);
    endfunction

    logic [1:0] raw_v;
    assign raw_v = {btn_rest_in, btn_sum_in};

    logic [1:0] m_s1, m_s2, m_stable, m_pulse, m_out, m_held;
    int m_run [2];
    int m_len [2];

    logic [1:0] n_stable, n_pulse, n_out;
    int n_run [2];
    int n_len [2];

    always_comb begin
        n_stable = m_stable;
        n_pulse  = '0;
        n_out    = '0;
        n_run    = m_run;
        n_len    = m_len;
        for (int c = 0; c < 2; c++) begin
            n_pulse[c] = m_stable[c] && fires(m_len[c]);
            n_out[c]   = m_pulse[c] && !(m_stable[0] && m_stable[1]);
            if (m_s2[c] != m_stable[c]) begin
                n_run[c] = m_run[c] + 1;
                if (n_run[c] == DEB) begin
                    n_stable[c] = ~m_stable[c];
                    n_run[c]    = 0;
                end
            end else begin
                n_run[c] = 0;
            end
            n_len[c] = n_stable[c] ? m_len[c] + 1 : 0;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1     <= '0;
            m_s2     <= '0;
            m_stable <= '0;
            m_pulse  <= '0;
            m_out    <= '0;
            m_held   <= '0;
            m_run    <= '{0, 0};
            m_len    <= '{0, 0};
        end else begin
            m_s1     <= raw_v;
            m_s2     <= m_s1;
            m_stable <= n_stable;
            m_pulse  <= n_pulse;
            m_out    <= n_out;
            m_held   <= m_stable;
            m_run    <= n_run;
            m_len    <= n_len;
        end
    end

    // ---------------- compare process + event logs ----------------
    int sum_log [$];
    int rest_log [$];
    int sheld_rise [$];
    logic prev_sum = 1'b0, prev_rest = 1'b0, prev_sh = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs", int'({sum, rest, sum_held, rest_held}), 0);
            prev_sum  <= 1'b0;
            prev_rest <= 1'b0;
            prev_sh   <= 1'b0;
        end else begin
            check("sum",       int'(sum),       int'(m_out[0]));
            check("rest",      int'(rest),      int'(m_out[1]));
            check("sum_held",  int'(sum_held),  int'(m_held[0]));
            check("rest_held", int'(rest_held), int'(m_held[1]));
            check("sum_rest_exclusive", int'(sum & rest), 0);
            check("sum_width",  int'(sum & prev_sum), 0);
            check("rest_width", int'(rest & prev_rest), 0);
            if (sum) sum_log.push_back(cyc);
            if (rest) rest_log.push_back(cyc);
            if (sum_held && !prev_sh) sheld_rise.push_back(cyc);
            prev_sum  <= sum;
            prev_rest <= rest;
            prev_sh   <= sum_held;
        end
    end

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
        return n;
    endfunction

    function automatic int nth_in(input int q[$], input int lo, input int hi, input int n);
        int seen = 0;
        foreach (q[i]) begin
            if (q[i] >= lo && q[i] < hi) begin
                if (seen == n) return q[i];
                seen++;
            end
        end
        return -1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    int k, kf, kr;

    initial begin
        wait_cyc(4);
        check("rst_sum",       int'(sum), 0);
        check("rst_rest",      int'(rest), 0);
        check("rst_sum_held",  int'(sum_held), 0);
        check("rst_rest_held", int'(rest_held), 0);
        rst = 1'b0;
        wait_cyc(5);

        // 1: clean 20-cycle press
        k = cyc + 1;
        btn_sum_in = 1'b1;
        wait_cyc(20);
        btn_sum_in = 1'b0;
        wait_cyc(60);
        check("t1_sum_count",   count_in(sum_log, k, k + 80), 1);
        check("t1_sum_cycle",   nth_in(sum_log, k, k + 80, 0), k + 11);
        check("t1_held_rise",   nth_in(sheld_rise, k, k + 80, 0), k + 10);
        check("t1_rest_count",  count_in(rest_log, k, k + 80), 0);

        // 2: bouncing decrement button, then a clean hold
        k = cyc + 1;
        for (int i = 0; i < 5; i++) begin
            btn_rest_in = 1'b1;
            wait_cyc(3);
            btn_rest_in = 1'b0;
            wait_cyc(3);
        end
        kf = cyc + 1;
        btn_rest_in = 1'b1;
        wait_cyc(20);
        btn_rest_in = 1'b0;
        wait_cyc(40);
        check("t2_rest_count", count_in(rest_log, k, kf + 60), 1);
        check("t2_rest_cycle", nth_in(rest_log, k, kf + 60, 0), kf + 11);
        check("t2_sum_count",  count_in(sum_log, k, kf + 60), 0);

        // 3: long hold; release lands exactly on a repeat slot (no pulse)
        k = cyc + 1;
        btn_sum_in = 1'b1;
        wait_cyc(80);
        btn_sum_in = 1'b0;
        wait_cyc(60);
        check("t3_sum_count", count_in(sum_log, k, k + 140), 7);
        check("t3_first",     nth_in(sum_log, k, k + 140, 0), k + 11);
        check("t3_hold_rep",  nth_in(sum_log, k, k + 140, 1), k + 43);
        check("t3_rep2",      nth_in(sum_log, k, k + 140, 2), k + 51);
        check("t3_last",      nth_in(sum_log, k, k + 140, 6), k + 83);

        // 4: glitches of 1 and 7 cycles
        k = cyc + 1;
        btn_sum_in = 1'b1;
        wait_cyc(1);
        btn_sum_in = 1'b0;
        wait_cyc(15);
        btn_sum_in = 1'b1;
        wait_cyc(7);
        btn_sum_in = 1'b0;
        wait_cyc(30);
        check("t4_sum_count",  count_in(sum_log, k, k + 60), 0);
        check("t4_held_rises", count_in(sheld_rise, k, k + 60), 0);

        // 5: both buttons down, sum released first
        k = cyc + 1;
        btn_sum_in = 1'b1;
        wait_cyc(4);
        btn_rest_in = 1'b1;
        wait_cyc(56);
        btn_sum_in = 1'b0;
        wait_cyc(40);
        btn_rest_in = 1'b0;
        wait_cyc(70);
        check("t5_sum_count",  count_in(sum_log, k, k + 170), 1);
        check("t5_sum_first",  nth_in(sum_log, k, k + 170, 0), k + 11);
        check("t5_rest_count", count_in(rest_log, k, k + 170), 5);
        check("t5_rest_first", nth_in(rest_log, k, k + 170, 0), k + 71);
        check("t5_rest_next",  nth_in(rest_log, k, k + 170, 1), k + 79);

        // 6: async reset while auto-repeating with the button still down
        k = cyc + 1;
        btn_sum_in = 1'b1;
        wait_cyc(55);
        check("t6_held_before_rst", int'(sum_held), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_sum",       int'(sum), 0);
        check("t6_async_sum_held",  int'(sum_held), 0);
        check("t6_async_rest_held", int'(rest_held), 0);
        wait_cyc(3);
        rst = 1'b0;
        kr = cyc + 1;
        wait_cyc(40);
        btn_sum_in = 1'b0;
        wait_cyc(30);
        check("t6_sum_first", nth_in(sum_log, kr, kr + 40, 0), kr + DEB + 3);
        check("t6_sum_count", count_in(sum_log, kr, kr + 40), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
